// File: rtl/time_of_day_counter.sv
// ----------------------------------------------------------------------------
// time_of_day_counter
//
// Time-of-day counter for the clock datapath. A seconds prescaler divides
// clk by TICK_DIV. A BCD digit chain (ss, mm, hh) advances once per second,
// and the hours and minutes fields can be stepped in set mode.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        1 = timekeeping enabled, 0 = hold all state
//   set_mode   0 run, 1 set hours, 2 set minutes, 3 hold (no field selected)
//   inc_pulse  increment request for the selected field
//   clr_sec    synchronous clear of the seconds and the prescaler
//   sec_ones/sec_tens, min_ones/min_tens, hr_ones/hr_tens   BCD digits
//   sec_tick   one-cycle pulse, high in the first cycle of a new second
//   day_wrap   one-cycle pulse, high in the first cycle of a new day
//   pm         PM indicator (tied to 0 in the 24-hour build)
//
// Build option
//   HOUR12_EN  defined   : 12-hour display (12, 01..11), pm toggles on 11->12
//              undefined : 24-hour display (00..23), pm = 0
// ----------------------------------------------------------------------------
module time_of_day_counter #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] set_mode,
    input  logic       inc_pulse,
    input  logic       clr_sec,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       pm
);

    localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

`ifdef HOUR12_EN
    localparam logic [1:0] HR_TENS_RST = 2'd1;
    localparam logic [3:0] HR_ONES_RST = 4'd2;
`else
    localparam logic [1:0] HR_TENS_RST = 2'd0;
    localparam logic [3:0] HR_ONES_RST = 4'd0;
`endif

    // Cycles left in the current second; a tick fires on the edge that sees 0.
    logic [PW-1:0] presc_remain, presc_next;
    logic          tick, inc_ok, min_adv, hr_adv;

    logic          sec_ones_wrap, sec_wrap, min_ones_wrap, min_wrap, hr_day_end;
    logic [3:0]    sec_ones_inc, min_ones_inc, hr_ones_inc;
    logic [2:0]    sec_tens_inc, min_tens_inc;
    logic [1:0]    hr_tens_inc;

    logic [3:0]    sec_ones_d, min_ones_d, hr_ones_d;
    logic [2:0]    sec_tens_d, min_tens_d;
    logic [1:0]    hr_tens_d;
    logic          sec_tick_d, day_wrap_d;

`ifdef HOUR12_EN
    logic          pm_q, hr_pm_flip;
`endif

    // Incremented values of each field. The >= compares send any
    // out-of-range digit back to a legal value instead of running past it.
    always_comb begin
        sec_ones_wrap = (sec_ones >= 4'd9);
        sec_wrap      = sec_ones_wrap && (sec_tens >= 3'd5);
        sec_ones_inc  = sec_ones_wrap ? 4'd0 : sec_ones + 4'd1;
        sec_tens_inc  = sec_ones_wrap ? (sec_wrap ? 3'd0 : sec_tens + 3'd1) : sec_tens;

        min_ones_wrap = (min_ones >= 4'd9);
        min_wrap      = min_ones_wrap && (min_tens >= 3'd5);
        min_ones_inc  = min_ones_wrap ? 4'd0 : min_ones + 4'd1;
        min_tens_inc  = min_ones_wrap ? (min_wrap ? 3'd0 : min_tens + 3'd1) : min_tens;

`ifdef HOUR12_EN
        hr_pm_flip  = 1'b0;
        hr_tens_inc = hr_tens;
        hr_ones_inc = hr_ones + 4'd1;
        if ((hr_tens != 2'd0) && (hr_ones >= 4'd2)) begin
            hr_tens_inc = 2'd0;
            hr_ones_inc = 4'd1;
        end else if ((hr_tens != 2'd0) && (hr_ones == 4'd1)) begin
            hr_tens_inc = 2'd1;
            hr_ones_inc = 4'd2;
            hr_pm_flip  = 1'b1;
        end else if (hr_ones >= 4'd9) begin
            hr_tens_inc = 2'd1;
            hr_ones_inc = 4'd0;
        end
        // The day ends when 11 PM rolls over to 12 AM.
        hr_day_end = hr_pm_flip && pm_q;
`else
        hr_day_end  = (hr_tens >= 2'd2) && (hr_ones >= 4'd3);
        hr_tens_inc = hr_tens;
        hr_ones_inc = hr_ones + 4'd1;
        if (hr_day_end) begin
            hr_tens_inc = 2'd0;
            hr_ones_inc = 4'd0;
        end else if (hr_ones >= 4'd9) begin
            hr_tens_inc = hr_tens + 2'd1;
            hr_ones_inc = 4'd0;
        end
`endif
    end

    always_comb begin
        // Any non-run mode parks the prescaler at the start of a second, so a
        // tick and a mode change in the same cycle resolve as if the mode
        // changed first.
        tick    = run && (set_mode == MODE_RUN) && !clr_sec && (presc_remain == '0);
        inc_ok  = run && inc_pulse;
        min_adv = (tick && sec_wrap) || (inc_ok && (set_mode == MODE_SET_MIN));
        hr_adv  = (tick && sec_wrap && min_wrap) || (inc_ok && (set_mode == MODE_SET_HR));

        presc_next = presc_remain;
        if (clr_sec || (set_mode != MODE_RUN) || tick) begin
            presc_next = PRESC_LOAD;
        end else if (run) begin
            presc_next = presc_remain - PW'(1);
        end

        sec_ones_d = sec_ones;
        sec_tens_d = sec_tens;
        if (clr_sec) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 3'd0;
        end else if (tick) begin
            sec_ones_d = sec_ones_inc;
            sec_tens_d = sec_tens_inc;
        end

        min_ones_d = min_adv ? min_ones_inc : min_ones;
        min_tens_d = min_adv ? min_tens_inc : min_tens;
        hr_ones_d  = hr_adv ? hr_ones_inc : hr_ones;
        hr_tens_d  = hr_adv ? hr_tens_inc : hr_tens;

        sec_tick_d = tick;
        day_wrap_d = tick && sec_wrap && min_wrap && hr_day_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_remain <= PRESC_LOAD;
            sec_ones     <= 4'd0;
            sec_tens     <= 3'd0;
            min_ones     <= 4'd0;
            min_tens     <= 3'd0;
            hr_ones      <= HR_ONES_RST;
            hr_tens      <= HR_TENS_RST;
            sec_tick     <= 1'b0;
            day_wrap     <= 1'b0;
        end else begin
            presc_remain <= presc_next;
            sec_ones     <= sec_ones_d;
            sec_tens     <= sec_tens_d;
            min_ones     <= min_ones_d;
            min_tens     <= min_tens_d;
            hr_ones      <= hr_ones_d;
            hr_tens      <= hr_tens_d;
            sec_tick     <= sec_tick_d;
            day_wrap     <= day_wrap_d;
        end
    end

`ifdef HOUR12_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q <= 1'b0;
        end else if (hr_adv && hr_pm_flip) begin
            pm_q <= !pm_q;
        end
    end

    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
module tb_time_of_day_counter;

    localparam int TD = 4;

`ifdef HOUR12_EN
    localparam int H0     = 12;   // reset hour
    localparam int WH     = 11;   // last hour of the day
    localparam int WPM    = 1;
    localparam int WRAP_H = 12;
`else
    localparam int H0     = 0;
    localparam int WH     = 23;
    localparam int WPM    = 0;
    localparam int WRAP_H = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] set_mode;
    logic       inc_pulse;
    logic       clr_sec;
    logic [3:0] sec_ones, min_ones, hr_ones;
    logic [2:0] sec_tens, min_tens;
    logic [1:0] hr_tens;
    logic       sec_tick, day_wrap, pm;

    time_of_day_counter #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .set_mode  (set_mode),
        .inc_pulse (inc_pulse),
        .clr_sec   (clr_sec),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .hr_ones   (hr_ones),
        .hr_tens   (hr_tens),
        .sec_tick  (sec_tick),
        .day_wrap  (day_wrap),
        .pm        (pm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    h;
        int    m;
        int    s;
        bit    pm;
        bit    tick;
        bit    wrap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;
    logic sample_req = 1'b0;

    // reference time-of-day
    int mh, mm, ms;
    bit mpm;

    // Monitor: pops one expectation whenever the DUT presents a second tick
    // or the stimulus requests a sample.
    always @(negedge clk) begin
        if (sample_req || sec_tick) begin
            n_run++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %0d%0d:%0d%0d:%0d%0d tick=%0b wrap=%0b, required no output",
                         hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, sec_tick, day_wrap);
            end else begin
                mon_e = sb.pop_front();
                if (!((int'(hr_tens)  == mon_e.h / 10) && (int'(hr_ones)  == mon_e.h % 10) &&
                      (int'(min_tens) == mon_e.m / 10) && (int'(min_ones) == mon_e.m % 10) &&
                      (int'(sec_tens) == mon_e.s / 10) && (int'(sec_ones) == mon_e.s % 10) &&
                      (pm == mon_e.pm) && (sec_tick == mon_e.tick) && (day_wrap == mon_e.wrap))) begin
                    n_fail++;
                    $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d pm=%0b tick=%0b wrap=%0b, required %02d:%02d:%02d pm=%0b tick=%0b wrap=%0b",
                             mon_e.name, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
                             pm, sec_tick, day_wrap, mon_e.h, mon_e.m, mon_e.s, mon_e.pm, mon_e.tick, mon_e.wrap);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input bit tick, input bit wrap);
        exp_t x;
        x.name = name;
        x.h = mh; x.m = mm; x.s = ms; x.pm = mpm;
        x.tick = tick; x.wrap = wrap;
        sb.push_back(x);
    endtask

    task automatic check_now(input string name, input bit tick, input bit wrap);
        push_exp(name, tick, wrap);
        sample_req = 1'b1;
        @(negedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic check_lit(input string name, input int h, input int m, input int s,
                             input bit p, input bit tick, input bit wrap);
        mh = h; mm = m; ms = s; mpm = p;
        check_now(name, tick, wrap);
    endtask

    task automatic m_hr_inc();
`ifdef HOUR12_EN
        if (mh == 11) begin
            mh  = 12;
            mpm = !mpm;
        end else if (mh == 12) begin
            mh = 1;
        end else begin
            mh++;
        end
`else
        mh = (mh + 1) % 24;
`endif
    endtask

    task automatic m_tick(output bit wrap);
        wrap = 1'b0;
        ms++;
        if (ms == 60) begin
            ms = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
`ifdef HOUR12_EN
                if (mh == 11 && mpm) wrap = 1'b1;
`else
                if (mh == 23) wrap = 1'b1;
`endif
                m_hr_inc();
            end
        end
    endtask

    // Checks that the next tick lands exactly TD edges from a fresh prescaler.
    task automatic second_exact(input string name);
        bit w;
        for (int i = 1; i < TD; i++) begin
            step();
            check_now({name, "_early"}, 1'b0, 1'b0);
        end
        step();
        m_tick(w);
        check_now(name, 1'b1, w);
    endtask

    task automatic run_ticks(input int n);
        bit w;
        for (int i = 0; i < n; i++) begin
            m_tick(w);
            push_exp("run_tick", 1'b1, w);
            repeat (TD) step();
        end
    endtask

    task automatic tick_expect(input string name, input int h, input int m, input int s,
                               input bit p, input bit wrap);
        mh = h; mm = m; ms = s; mpm = p;
        push_exp(name, 1'b1, wrap);
        repeat (TD) step();
    endtask

    task automatic inc_n(input int n, input logic [1:0] mode);
        set_mode  = mode;
        inc_pulse = 1'b1;
        repeat (n) step();
        inc_pulse = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; set_mode = 2'd0; inc_pulse = 1'b0; clr_sec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_lit("reset", H0, 0, 0, 0, 1'b0, 1'b0);

        // first second after release, then an async reset mid-second
        rst_n = 1'b1; run = 1'b1;
        second_exact("first_sec");
        step(); step();
        rst_n = 1'b0;
        check_lit("async_reset", H0, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        second_exact("resume_sec");
        step();

        // minute set, set-field wrap, set-mode hold
        inc_n(59, 2'd2);
        check_lit("min_set_59", H0, 59, 1, 0, 1'b0, 1'b0);
        inc_n(1, 2'd2);
        check_lit("min_set_wrap", H0, 0, 1, 0, 1'b0, 1'b0);
        inc_n(59, 2'd2);
        set_mode = 2'd1;
        repeat (10 * TD) step();
        check_lit("set_hold", H0, 59, 1, 0, 1'b0, 1'b0);

        clr_sec = 1'b1; set_mode = 2'd0;
        step();
        clr_sec = 1'b0;
        check_lit("clr_in_set", H0, 59, 0, 0, 1'b0, 1'b0);

        // minute and hour carry on a single edge
        second_exact("after_clr");
        run_ticks(58);
        tick_expect("hour_carry", 1, 0, 0, 0, 1'b0);

        // clr_sec on the terminal-count cycle suppresses the tick
        repeat (TD - 1) step();
        clr_sec = 1'b1;
        step();
        clr_sec = 1'b0;
        check_lit("clr_collide", 1, 0, 0, 0, 1'b0, 1'b0);
        second_exact("after_collide");

        // run=0 holds everything and ignores increments
        run = 1'b0;
        inc_n(3, 2'd1);
        set_mode = 2'd0;
        repeat (3 * TD) step();
        check_lit("run_off_hold", 1, 0, 1, 0, 1'b0, 1'b0);
        run = 1'b1;

`ifdef HOUR12_EN
        inc_n(10, 2'd1);
        check_lit("hr12_11am", 11, 0, 1, 0, 1'b0, 1'b0);
        inc_n(1, 2'd1);
        check_lit("hr12_noon", 12, 0, 1, 1, 1'b0, 1'b0);
        inc_n(11, 2'd1);
        check_lit("hr12_11pm", 11, 0, 1, 1, 1'b0, 1'b0);
`else
        inc_n(22, 2'd1);
        check_lit("hr_set_23", 23, 0, 1, 0, 1'b0, 1'b0);
        inc_n(1, 2'd1);
        check_lit("hr_set_wrap", 0, 0, 1, 0, 1'b0, 1'b0);
        inc_n(23, 2'd1);
        check_lit("hr_set_23b", 23, 0, 1, 0, 1'b0, 1'b0);
`endif
        inc_n(59, 2'd2);
        check_lit("min_59", WH, 59, 1, WPM, 1'b0, 1'b0);
        clr_sec = 1'b1; set_mode = 2'd0;
        step();
        clr_sec = 1'b0;
        check_lit("pre_wrap_clr", WH, 59, 0, WPM, 1'b0, 1'b0);

        // day wrap
        second_exact("wrap_run_start");
        run_ticks(58);
        tick_expect("day_wrap", WRAP_H, 0, 0, 0, 1'b1);
        step();
        check_now("wrap_one_cycle", 1'b0, 1'b0);

        repeat (2) step();
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_ticks: got %0d outstanding expectations, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
Time-of-day counter for the clock datapath, running on the system clock. It contains a seconds prescaler and a chain of BCD digit counters for seconds, minutes and hours. It produces the count-enable and carry events that drive the toggle-flop digit stages, and presents the BCD digits to the display mux. Set-mode inputs come from the debounced button front end.

Parameters:
TICK_DIV, 100000000, clk cycles per second; legal range 2..2^27.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = timekeeping enabled; 0 = hold all state
set_mode  in  2  0 = run, 1 = set hours, 2 = set minutes, 3 = hold (treated as set with no field)
inc_pulse  in  1  single-cycle increment request for the selected field
clr_sec  in  1  synchronous clear of seconds and prescaler
sec_ones  out  4  BCD 0..9
sec_tens  out  3  0..5
min_ones  out  4  BCD 0..9
min_tens  out  3  0..5
hr_ones  out  4  BCD 0..9
hr_tens  out  2  0..2
sec_tick  out  1  one-cycle pulse, high in the first cycle the new second is visible
day_wrap  out  1  one-cycle pulse, high in the first cycle 00:00:00 (or 12:00:00 AM) is visible
pm  out  1  PM indicator (see Optional Feature)

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears all outputs, the prescaler and the pulses to 0, including mid-second.
  - In HOUR12_EN builds, the hours reset to 12 (hr_tens=1, hr_ones=2) and pm=0.
  - Counting resumes from a full TICK_DIV period after the first clk edge with rst_n high.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when run=1, set_mode=0 and clr_sec=0.
  - Wraps to 0 at TICK_DIV-1; that edge advances the seconds.
  - Period is exactly TICK_DIV cycles.
- Holding:
  - With run=0, the prescaler and all digits hold.
  - set_mode≠0 forces the prescaler to 0 and blocks the tick.
- Pulses and latency:
  - Digits and sec_tick/day_wrap are registered.
  - Digits change at the same edge that raises sec_tick.
  - sec_tick and day_wrap deassert on the following edge.
- Carry chain, all digits updated on one edge:
  - sec_ones 9→0 carries to sec_tens.
  - sec 59→00 carries to min.
  - min 59→00 carries to hours.
  - 23:59:59→00:00:00 asserts day_wrap with that sec_tick.
- Set mode:
  - inc_pulse with set_mode=1 increments hours 00..23 then wraps to 00.
  - inc_pulse with set_mode=2 increments minutes 00..59 then wraps to 00.
  - No carry out of a set field; seconds are unchanged; no sec_tick or day_wrap is generated.
  - inc_pulse is ignored when set_mode is 0 or 3, or when run=0.
  - A multi-cycle inc_pulse increments once per high cycle; the front end guarantees single-cycle pulses.
- clr_sec:
  - Zeroes the seconds and the prescaler on the next edge, in any mode.
  - Takes priority over a coincident tick; no sec_tick is generated in that cycle.
- Simultaneous events: a tick and a set_mode change in the same cycle resolve as if set_mode changed first.
- Invalid BCD: unreachable. The implementation must never produce a digit above its stated maximum.

Optional Feature:
HOUR12_EN
- Defined:
  - Hours run in the sequence 12, 01, ..., 11, 12.
  - pm toggles on 11→12, both by carry and by set increment.
  - day_wrap fires on 11:59:59 PM → 12:00:00 AM.
  - Reset value is 12:00:00 AM.
- Undefined:
  - Hours run 00..23 as in Behaviour.
  - pm is tied to 0.

Test Plan:
- Reset mid-count: TICK_DIV=4, run=1, pull rst_n low at cycle 6 → all digits 0, sec_tick=0 immediately. After release, first sec_tick at exactly cycle 4 after release with sec_ones=1.
- Minute/hour carry: preset 00:59:59 via set mode (hours 0, minutes 59), clr_sec, run; advance 59 ticks then 1 more → 01:00:00 on one edge, sec_tick=1, day_wrap=0.
- Day wrap: set 23:59, run 60 ticks → 00:00:00 with day_wrap=1 for exactly one cycle, coincident with sec_tick.
- Set mode isolation: set_mode=2, minutes=59, inc_pulse → minutes 00, hours unchanged, no sec_tick. Hold set_mode=1 for 10·TICK_DIV cycles → seconds unchanged, prescaler at 0.
- clr_sec vs tick collision: assert clr_sec in the cycle the prescaler equals TICK_DIV-1 → seconds 00, sec_tick stays 0, next sec_tick after a full TICK_DIV.
- HOUR12_EN build: from reset 12:00:00 AM, set hours ×11 → 11 AM, ×1 → 12 with pm=1. Run 11:59:59 PM + 1 tick → 12:00:00, pm=0, day_wrap=1.
